// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/func constants and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StExecI    = 4'd10,
    StIWb      = 4'd11,
    StTrap     = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // States in which an instruction completes.
  function automatic logic is_final(state_e s);
    return (s == StRWb) || (s == StMemWb) || (s == StMemWrite) ||
           (s == StBranch) || (s == StJump) || (s == StIWb);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// R-type function field decoder: maps func to an ALU operation and flags
// unsupported function codes.
module alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [2:0] alu_op_o,
  output logic       func_valid_o
);

  always_comb begin
    alu_op_o     = AluAdd;
    func_valid_o = 1'b1;
    case (func_i)
      FnAdd:   alu_op_o = AluAdd;
      FnSub:   alu_op_o = AluSub;
      FnAnd:   alu_op_o = AluAnd;
      FnOr:    alu_op_o = AluOr;
      FnSlt:   alu_op_o = AluSlt;
      default: func_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls, sticky
// illegal-instruction flag and a retired-instruction counter.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        alu_zout,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic        illegal_q;
  logic [31:0] retired_q;
  logic [2:0]  r_alu_op;
  logic        func_valid;

  alu_decode u_alu_decode (
    .func_i       (func),
    .alu_op_o     (r_alu_op),
    .func_valid_o (func_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (is_final(state_q)) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = AluAnd;
    unique case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = AluAdd;
        pc_write  = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b10;
        alu_op    = AluAdd;
        case (opcode)
          OpRtype:    state_d = func_valid ? StExecR : StTrap;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StExecI;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = AluAdd;
        // IR is stable after FETCH, so opcode still tells lw from sw here.
        state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        i_or_d  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = StFetch;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        pc_src    = 2'b01;
        pc_write  = alu_zout;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = AluAdd;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    // Reset forces FETCH asynchronously; keep its strobes quiet until release.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        alu_zout;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .func       (func),
    .alu_zout   (alu_zout),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  logic [5:0] fn_tab [5];
  logic [2:0] op_tab [5];

  initial begin
    fn_tab[0] = 6'h20; op_tab[0] = 3'b010;
    fn_tab[1] = 6'h22; op_tab[1] = 3'b110;
    fn_tab[2] = 6'h24; op_tab[2] = 3'b000;
    fn_tab[3] = 6'h25; op_tab[3] = 3'b001;
    fn_tab[4] = 6'h2A; op_tab[4] = 3'b111;

    reset = 1'b1; opcode = 6'h00; func = 6'h20; alu_zout = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ir_write", ir_write, 0);
    step();
    chk("rst_hold_state", state, 0);
    release_reset();

    // add
    chk("fetch_state", state, 0);
    chk("fetch_pc_write", pc_write, 1);
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_src_b", alu_src_b, 2'b01);
    chk("fetch_alu_op", alu_op, 3'b010);
    step(); chk("add_decode", state, 1);
    chk("decode_src_b", alu_src_b, 2'b10);
    step(); chk("add_exec", state, 6);
    chk("add_alu_op", alu_op, 3'b010);
    chk("add_src_a", alu_src_a, 1);
    step(); chk("add_rwb", state, 7);
    chk("add_reg_write", reg_write, 1);
    chk("add_reg_dst", reg_dst, 1);
    chk("add_mem_to_reg", mem_to_reg, 0);
    chk("add_ret_before", retired, 0);
    step(); chk("add_done", state, 0);
    chk("add_retired", retired, 1);

    // lw
    opcode = 6'h23;
    step(); chk("lw_decode", state, 1);
    step(); chk("lw_memaddr", state, 2);
    chk("lw_src_b", alu_src_b, 2'b10);
    step(); chk("lw_memread", state, 3);
    chk("lw_i_or_d", i_or_d, 1);
    step(); chk("lw_memwb", state, 4);
    chk("lw_mem_to_reg", mem_to_reg, 1);
    chk("lw_reg_write", reg_write, 1);
    chk("lw_reg_dst", reg_dst, 0);
    step(); chk("lw_done", state, 0);
    chk("lw_retired", retired, 2);

    // beq taken then not-taken in the same BRANCH cycle
    opcode = 6'h04; alu_zout = 1'b1;
    step(); step(); chk("beq_branch", state, 8);
    chk("beq_pc_write1", pc_write, 1);
    chk("beq_pc_src", pc_src, 2'b01);
    chk("beq_alu_op", alu_op, 3'b110);
    alu_zout = 1'b0; #1;
    chk("beq_pc_write0", pc_write, 0);
    step(); chk("beq_done", state, 0);
    chk("beq_retired", retired, 3);

    // addi
    opcode = 6'h08;
    step(); step(); chk("addi_exec", state, 10);
    chk("addi_src_b", alu_src_b, 2'b10);
    step(); chk("addi_iwb", state, 11);
    chk("addi_reg_write", reg_write, 1);
    chk("addi_reg_dst", reg_dst, 0);
    step(); chk("addi_retired", retired, 4);

    // R-type ALU op table
    opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      func = fn_tab[i];
      step(); step();
      chk("rtype_state", state, 6);
      chk("rtype_alu_op", alu_op, op_tab[i]);
      step(); step();
    end
    chk("rtype_retired", retired, 9);

    // sw, reset mid MEM_WRITE
    opcode = 6'h2B;
    step(); step(); chk("sw_memaddr", state, 2);
    step(); chk("sw_memwrite", state, 5);
    chk("sw_mem_write", mem_write, 1);
    chk("sw_i_or_d", i_or_d, 1);
    reset = 1'b1; #1;
    chk("sw_rst_mem_write", mem_write, 0);
    chk("sw_rst_state", state, 0);
    chk("sw_rst_retired", retired, 0);
    release_reset();

    // j with counter at wrap point
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    opcode = 6'h02;
    step(); step(); chk("j_jump", state, 9);
    chk("j_pc_write", pc_write, 1);
    chk("j_pc_src", pc_src, 2'b10);
    chk("j_ret_pre", retired, 32'hFFFF_FFFF);
    step(); chk("j_done", state, 0);
    chk("j_wrap", retired, 0);

    // illegal opcode
    opcode = 6'h3F;
    step(); step(); chk("ill_trap", state, 15);
    chk("ill_flag", illegal, 1);
    chk("ill_pc_write", pc_write, 0);
    chk("ill_ir_write", ir_write, 0);
    step(); step(); chk("ill_hold", state, 15);
    chk("ill_retired", retired, 0);
    reset = 1'b1; #1;
    chk("ill_rst_state", state, 0);
    chk("ill_rst_flag", illegal, 0);
    release_reset();

    // illegal func
    opcode = 6'h00; func = 6'h01;
    step(); chk("ilf_decode", state, 1);
    step(); chk("ilf_trap", state, 15);
    chk("ilf_flag", illegal, 1);
    step(); chk("ilf_retired", retired, 0);
    reset = 1'b1; #1;
    chk("ilf_rst_state", state, 0);
    release_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 Port clk  in  1  system clock; all state updates on posedge.
REQ-003 Port reset  in  1  asynchronous active-high reset.
REQ-004 Port opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 Port func  in  6  instruction[5:0] from the instruction register.
REQ-006 Port alu_zout  in  1  ALU zero flag.
REQ-007 Port pc_write  out  1  load PC.
REQ-008 Port pc_src  out  2  PC source: 00 ALU result (pc+1), 01 ALUOut (branch target), 10 jump {pc[29:26],addr26}.
REQ-009 Port ir_write  out  1  load instruction register.
REQ-010 Port i_or_d  out  1  memory address source: 0 PC, 1 ALUOut.
REQ-011 Port mem_write  out  1  data memory write strobe.
REQ-012 Port reg_write  out  1  register file write strobe.
REQ-013 Port reg_dst  out  1  write address: 0 rt, 1 rd.
REQ-014 Port mem_to_reg  out  1  write data: 0 ALUOut, 1 memory data register.
REQ-015 Port alu_src_a  out  1  ALU A: 0 PC, 1 register A.
REQ-016 Port alu_src_b  out  2  ALU B: 00 register B, 01 constant 1, 10 sign-extended imm16.
REQ-017 Port alu_op  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-018 Port state  out  4  current state encoding (debug).
REQ-019 Port illegal  out  1  sticky illegal-instruction flag.
REQ-020 Port retired  out  32  count of completed instructions.

Function
REQ-021 The block SHALL use states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=15.
REQ-022 All outputs except pc_write in BRANCH SHALL be Moore, decoded from state only; strobes default 0, selects default 0.
REQ-023 FETCH: i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=010, pc_src=00, pc_write=1; next DECODE.
REQ-024 DECODE: alu_src_a=0, alu_src_b=10, alu_op=010 (branch target into ALUOut); next state by opcode: 000000->EXEC_R, 100011 lw / 101011 sw->MEM_ADDR, 000100 beq->BRANCH, 000010 j->JUMP, 001000 addi->EXEC_I, any other->TRAP.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from func (100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111); next R_WB; any other func from DECODE SHALL go to TRAP instead of EXEC_R.
REQ-026 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010; next MEM_READ for lw, MEM_WRITE for sw.
REQ-028 MEM_READ: i_or_d=1; next MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-029 MEM_WRITE: i_or_d=1, mem_write=1; next FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_write=alu_zout (combinational); next FETCH.
REQ-031 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-032 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=010; next I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-033 Latency in cycles including FETCH SHALL be: beq 3, j 3, sw 4, R-type 4, addi 4, lw 5.
REQ-034 TRAP SHALL hold all strobes 0, set illegal=1, and remain until reset.
REQ-035 retired SHALL increment by 1 on the final cycle of each instruction (R_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP, I_WB), wrapping 0xFFFFFFFF->0, never in TRAP.

Reset
REQ-036 While reset=1: state=FETCH, illegal=0, retired=0, asynchronously; first FETCH strobes occur on the first posedge after reset falls.
REQ-037 Reset asserted mid-instruction (e.g. in MEM_WRITE) SHALL suppress that cycle's strobes immediately.

Structure
REQ-038 State encodings, opcode/func constants and alu_op codes SHALL live in shared package mips_ctrl_pkg.
REQ-039 One sub-module, alu_decode (func -> alu_op, func_valid), SHALL be instantiated.

Verification
REQ-040 add (opcode 0, func 0x20) -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 in R_WB; retired +1.
REQ-041 lw (0x23) -> 5-cycle sequence 0,1,2,3,4; i_or_d=1 in MEM_READ; mem_to_reg=1 in MEM_WB.
REQ-042 beq (0x04) with alu_zout=1 -> pc_write=1, pc_src=01 in BRANCH; with alu_zout=0 -> pc_write=0; both retire.
REQ-043 opcode 0x3F, or opcode 0 with func 0x01 -> TRAP after DECODE, illegal=1, retired frozen, reset recovers to FETCH.
REQ-044 reset pulse during MEM_WRITE -> mem_write drops same cycle, state=0, retired=0.
REQ-045 retired preloaded to 0xFFFFFFFF by force, j instruction -> retired=0 after JUMP.
